ann_load_sequencer: RTL and testbench
=====================================

// Module: ann_load_sequencer
// PURPOSE
//  Drains the shared 11-bit input FIFO and routes words to the accelerator's stores in order:
//  KD-tree internal nodes, then leaf patches, then query patches.
//  Packs multi-word records before each write. Hands query patches to the search engine over valid/ready.
//  Sits between the io-side input FIFO and the node/leaf memories plus the query path.
// PARAMETERS
//  DATA_WIDTH   11   bits per FIFO word / patch element
//  PATCH_SIZE   5    data words per patch
//  LEAF_SIZE    8    patches per leaf
//  NUM_LEAVES   64   leaves; internal nodes = NUM_LEAVES-1
//  NUM_QUERYS   494  query patches per frame (26x19)
// PORTS
//  io_clk          in   1                       clock
//  io_rst_n        in   1                       async active-low reset
//  load_kdtree     in   1                       1-cycle start pulse
//  in_fifo_rdata   in   DATA_WIDTH              FIFO head word (show-ahead)
//  in_fifo_rempty_n in  1                       FIFO non-empty
//  in_fifo_deq     out  1                       pop head this cycle
//  node_wen        out  1                       node memory write strobe
//  node_waddr      out  clog2(NUM_LEAVES-1)     node number
//  node_wdata      out  2*DATA_WIDTH            {index, median}
//  leaf_wen        out  1                       leaf memory write strobe
//  leaf_waddr      out  clog2(NUM_LEAVES)       leaf number
//  leaf_wpatch     out  clog2(LEAF_SIZE)        patch slot in leaf
//  leaf_wdata      out  (PATCH_SIZE+1)*DATA_WIDTH {orig_idx, w4..w0}; w0 in LSBs
//  query_valid     out  1                       query patch available
//  query_ready     in   1                       engine accepts patch
//  query_data      out  PATCH_SIZE*DATA_WIDTH   {w4..w0}; w0 in LSBs
//  query_idx       out  clog2(NUM_QUERYS)       query number 0..NUM_QUERYS-1
//  busy            out  1                       state != IDLE
//  load_done       out  1                       1-cycle pulse when last query is accepted
// BEHAVIOUR
//  Reset: all outputs and counters 0; state IDLE. Reset mid-load aborts cleanly and discards partial records.
//  Word accept: acc = in_fifo_deq & in_fifo_rempty_n.
//   in_fifo_deq = rempty_n & state in {NODE,LEAF,QWORD}; it is never asserted in IDLE or QHOLD.
//   Empty gaps stall the counters; no word is lost or duplicated.
//  FSM: IDLE -> NODE on load_kdtree. load_kdtree is ignored while busy.
//   NODE: words alternate index, median. Index is latched on the even word.
//    On the odd word: node_wen=1 for one cycle, registered; node_wdata={index,median}.
//    After node NUM_LEAVES-2 is written -> LEAF.
//   LEAF: PATCH_SIZE data words are shifted into a packer, then 1 orig-index word.
//    On the index word: leaf_wen=1 with the current leaf/patch.
//    patch increments; it wraps at LEAF_SIZE-1 and bumps leaf.
//    After leaf NUM_LEAVES-1 patch LEAF_SIZE-1 -> QWORD.
//   QWORD: PATCH_SIZE words are packed. On the last word -> QHOLD with query_valid=1, registered.
//   QHOLD: query_data and query_idx stay stable until query_valid & query_ready.
//    The accept cycle clears query_valid and increments query_idx.
//    Goes to QWORD, or on query NUM_QUERYS-1 -> IDLE with load_done=1.
//    The next patch's words are not popped during QHOLD.
//  Latency: write strobe / query_valid asserts the cycle after the final word is accepted.
//  Counters reset to 0 on every IDLE->NODE transition.
//  Write strobes are mutually exclusive and never back-to-back within one record.
// TESTING
//  T1: load_kdtree, then FIFO words i=0..125 with no gaps
//   -> 63 node writes; node0 wdata={0,1}; node62 {124,125}; state LEAF.
//  T2: leaf words i=0..3071
//   -> 512 leaf writes; leaf0/patch0 {5,4,3,2,1,0}; leaf63/patch7 idx word 3071; state QWORD.
//  T3: queries i=0..2469 with query_ready=1
//   -> 494 patches; query0 {4..0}; query_idx 493 last; load_done pulses once; busy falls.
//  T4: query_ready=0 for 20 cycles during QHOLD
//   -> data stable; in_fifo_deq=0; no FIFO pop; resumes after ready.
//  T5: random rempty_n gaps and a load_kdtree pulse mid-LEAF
//   -> same write stream as T1/T2; pulse ignored.
//  T6: io_rst_n low mid-NODE, then a fresh load
//   -> outputs 0 on reset; next load writes node0 from the first new words.

Source files
------------

// File: rtl/ann_load_sequencer.sv
// Drains the shared input FIFO in load order: KD-tree nodes, then leaf patches, then query
// patches. Packs each multi-word record and writes it, or hands it to the search engine.
module ann_load_sequencer #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_QUERYS = 494,
  localparam int NODE_AW   = $clog2(NUM_LEAVES - 1),
  localparam int LEAF_AW   = $clog2(NUM_LEAVES),
  localparam int PATCH_AW  = $clog2(LEAF_SIZE),
  localparam int QIDX_W    = $clog2(NUM_QUERYS),
  localparam int PACK_W    = PATCH_SIZE * DATA_WIDTH
) (
  input  logic                             io_clk,
  input  logic                             io_rst_n,
  input  logic                             load_kdtree,
  input  logic [DATA_WIDTH-1:0]            in_fifo_rdata,
  input  logic                             in_fifo_rempty_n,
  output logic                             in_fifo_deq,
  output logic                             node_wen,
  output logic [NODE_AW-1:0]               node_waddr,
  output logic [2*DATA_WIDTH-1:0]          node_wdata,
  output logic                             leaf_wen,
  output logic [LEAF_AW-1:0]               leaf_waddr,
  output logic [PATCH_AW-1:0]              leaf_wpatch,
  output logic [(PATCH_SIZE+1)*DATA_WIDTH-1:0] leaf_wdata,
  output logic                             query_valid,
  input  logic                             query_ready,
  output logic [PACK_W-1:0]                query_data,
  output logic [QIDX_W-1:0]                query_idx,
  output logic                             busy,
  output logic                             load_done
);

  localparam int WCNT_W = $clog2(PATCH_SIZE + 1);

  typedef enum logic [2:0] {S_IDLE, S_NODE, S_LEAF, S_QWORD, S_QHOLD} state_e;

  state_e                          state_q, state_d;
  logic [WCNT_W-1:0]               word_cnt_q, word_cnt_d;
  logic [NODE_AW-1:0]              node_cnt_q, node_cnt_d;
  logic [LEAF_AW-1:0]              leaf_cnt_q, leaf_cnt_d;
  logic [PATCH_AW-1:0]             patch_cnt_q, patch_cnt_d;
  logic [QIDX_W-1:0]               query_idx_q, query_idx_d;
  logic [DATA_WIDTH-1:0]           index_q, index_d;
  logic [PACK_W-1:0]               pack_q, pack_d;
  logic                            node_wen_q, node_wen_d;
  logic [NODE_AW-1:0]              node_waddr_q, node_waddr_d;
  logic [2*DATA_WIDTH-1:0]         node_wdata_q, node_wdata_d;
  logic                            leaf_wen_q, leaf_wen_d;
  logic [LEAF_AW-1:0]              leaf_waddr_q, leaf_waddr_d;
  logic [PATCH_AW-1:0]             leaf_wpatch_q, leaf_wpatch_d;
  logic [(PATCH_SIZE+1)*DATA_WIDTH-1:0] leaf_wdata_q, leaf_wdata_d;
  logic                            query_valid_q, query_valid_d;
  logic                            load_done_q, load_done_d;

  // A word is consumed only in the word-collecting states; QHOLD back-pressures the FIFO.
  assign in_fifo_deq = in_fifo_rempty_n &&
                       (state_q inside {S_NODE, S_LEAF, S_QWORD});

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    node_cnt_d    = node_cnt_q;
    leaf_cnt_d    = leaf_cnt_q;
    patch_cnt_d   = patch_cnt_q;
    query_idx_d   = query_idx_q;
    index_d       = index_q;
    pack_d        = pack_q;
    node_wen_d    = 1'b0;
    node_waddr_d  = node_waddr_q;
    node_wdata_d  = node_wdata_q;
    leaf_wen_d    = 1'b0;
    leaf_waddr_d  = leaf_waddr_q;
    leaf_wpatch_d = leaf_wpatch_q;
    leaf_wdata_d  = leaf_wdata_q;
    query_valid_d = query_valid_q;
    load_done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_kdtree) begin
          state_d     = S_NODE;
          word_cnt_d  = '0;
          node_cnt_d  = '0;
          leaf_cnt_d  = '0;
          patch_cnt_d = '0;
          query_idx_d = '0;
        end
      end

      S_NODE: begin
        if (in_fifo_deq) begin
          if (!word_cnt_q[0]) begin
            index_d    = in_fifo_rdata;
            word_cnt_d = WCNT_W'(1);
          end else begin
            word_cnt_d   = '0;
            node_wen_d   = 1'b1;
            node_waddr_d = node_cnt_q;
            node_wdata_d = {index_q, in_fifo_rdata};
            node_cnt_d   = node_cnt_q + 1'b1;
            if (node_cnt_q == NODE_AW'(NUM_LEAVES - 2)) begin
              state_d    = S_LEAF;
              node_cnt_d = '0;
            end
          end
        end
      end

      S_LEAF: begin
        if (in_fifo_deq) begin
          if (word_cnt_q == WCNT_W'(PATCH_SIZE)) begin
            // Trailing word is the original patch index; the packer already holds w4..w0.
            word_cnt_d    = '0;
            leaf_wen_d    = 1'b1;
            leaf_waddr_d  = leaf_cnt_q;
            leaf_wpatch_d = patch_cnt_q;
            leaf_wdata_d  = {in_fifo_rdata, pack_q};
            patch_cnt_d   = patch_cnt_q + 1'b1;
            if (patch_cnt_q == PATCH_AW'(LEAF_SIZE - 1)) begin
              patch_cnt_d = '0;
              leaf_cnt_d  = leaf_cnt_q + 1'b1;
              if (leaf_cnt_q == LEAF_AW'(NUM_LEAVES - 1)) begin
                state_d    = S_QWORD;
                leaf_cnt_d = '0;
              end
            end
          end else begin
            pack_d     = {in_fifo_rdata, pack_q[PACK_W-1:DATA_WIDTH]};
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end

      S_QWORD: begin
        if (in_fifo_deq) begin
          pack_d = {in_fifo_rdata, pack_q[PACK_W-1:DATA_WIDTH]};
          if (word_cnt_q == WCNT_W'(PATCH_SIZE - 1)) begin
            word_cnt_d    = '0;
            state_d       = S_QHOLD;
            query_valid_d = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end

      S_QHOLD: begin
        if (query_ready) begin
          query_valid_d = 1'b0;
          query_idx_d   = query_idx_q + 1'b1;
          if (query_idx_q == QIDX_W'(NUM_QUERYS - 1)) begin
            state_d     = S_IDLE;
            load_done_d = 1'b1;
          end else begin
            state_d = S_QWORD;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the packer is ordinary flops, not RAM, so it is reset with everything else.
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state_q       <= S_IDLE;
      word_cnt_q    <= '0;
      node_cnt_q    <= '0;
      leaf_cnt_q    <= '0;
      patch_cnt_q   <= '0;
      query_idx_q   <= '0;
      index_q       <= '0;
      pack_q        <= '0;
      node_wen_q    <= 1'b0;
      node_waddr_q  <= '0;
      node_wdata_q  <= '0;
      leaf_wen_q    <= 1'b0;
      leaf_waddr_q  <= '0;
      leaf_wpatch_q <= '0;
      leaf_wdata_q  <= '0;
      query_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      node_cnt_q    <= node_cnt_d;
      leaf_cnt_q    <= leaf_cnt_d;
      patch_cnt_q   <= patch_cnt_d;
      query_idx_q   <= query_idx_d;
      index_q       <= index_d;
      pack_q        <= pack_d;
      node_wen_q    <= node_wen_d;
      node_waddr_q  <= node_waddr_d;
      node_wdata_q  <= node_wdata_d;
      leaf_wen_q    <= leaf_wen_d;
      leaf_waddr_q  <= leaf_waddr_d;
      leaf_wpatch_q <= leaf_wpatch_d;
      leaf_wdata_q  <= leaf_wdata_d;
      query_valid_q <= query_valid_d;
      load_done_q   <= load_done_d;
    end
  end

  assign node_wen    = node_wen_q;
  assign node_waddr  = node_waddr_q;
  assign node_wdata  = node_wdata_q;
  assign leaf_wen    = leaf_wen_q;
  assign leaf_waddr  = leaf_waddr_q;
  assign leaf_wpatch = leaf_wpatch_q;
  assign leaf_wdata  = leaf_wdata_q;
  assign query_valid = query_valid_q;
  assign query_data  = pack_q;
  assign query_idx   = query_idx_q;
  assign busy        = (state_q != S_IDLE);
  assign load_done   = load_done_q;

endmodule

// File: tb/tb_ann_load_sequencer.sv
// Bench for ann_load_sequencer: a FIFO model feeds whole loads; expected node, leaf and query
// records are derived straight from the pushed word stream and compared every cycle.
module tb_ann_load_sequencer;
  localparam int DW = 11, PS = 5, LS = 8, NL = 64, NQ = 494;
  localparam int NODE_AW  = $clog2(NL - 1);
  localparam int LEAF_AW  = $clog2(NL);
  localparam int PATCH_AW = $clog2(LS);
  localparam int QIDX_W   = $clog2(NQ);
  localparam int QDW = PS * DW;
  localparam int LDW = (PS + 1) * DW;

  logic                io_clk = 1'b0;
  logic                io_rst_n = 1'b0;
  logic                load_kdtree = 1'b0;
  logic [DW-1:0]       in_fifo_rdata = '0;
  logic                in_fifo_rempty_n = 1'b0;
  logic                in_fifo_deq;
  logic                node_wen;
  logic [NODE_AW-1:0]  node_waddr;
  logic [2*DW-1:0]     node_wdata;
  logic                leaf_wen;
  logic [LEAF_AW-1:0]  leaf_waddr;
  logic [PATCH_AW-1:0] leaf_wpatch;
  logic [LDW-1:0]      leaf_wdata;
  logic                query_valid;
  logic                query_ready = 1'b0;
  logic [QDW-1:0]      query_data;
  logic [QIDX_W-1:0]   query_idx;
  logic                busy;
  logic                load_done;

  ann_load_sequencer dut (
    .io_clk(io_clk), .io_rst_n(io_rst_n), .load_kdtree(load_kdtree),
    .in_fifo_rdata(in_fifo_rdata), .in_fifo_rempty_n(in_fifo_rempty_n), .in_fifo_deq(in_fifo_deq),
    .node_wen(node_wen), .node_waddr(node_waddr), .node_wdata(node_wdata),
    .leaf_wen(leaf_wen), .leaf_waddr(leaf_waddr), .leaf_wpatch(leaf_wpatch), .leaf_wdata(leaf_wdata),
    .query_valid(query_valid), .query_ready(query_ready), .query_data(query_data),
    .query_idx(query_idx), .busy(busy), .load_done(load_done)
  );

  always #5 io_clk = ~io_clk;

  int total = 0, bad = 0;

  logic [DW-1:0]                        fifo_q[$];
  logic [NODE_AW+2*DW-1:0]              exp_node[$];
  logic [LEAF_AW+PATCH_AW+LDW-1:0]      exp_leaf[$];
  logic [QIDX_W+QDW-1:0]                exp_query[$];

  // Owned by the compare process
  bit pop_pending = 1'b0, exp_busy = 1'b0, done_exp = 1'b0;
  int node_seen = 0, leaf_seen = 0, q_seen = 0, q_acc = 0, done_seen = 0, hold_seen = 0;
  logic [2*DW-1:0]   cap_node0 = '0, cap_node62 = '0;
  logic [LDW-1:0]    cap_leaf0 = '0;
  logic [DW-1:0]     cap_leaf_last_idx = '0;
  logic [QDW-1:0]    cap_q0 = '0;
  logic [QIDX_W-1:0] cap_qlast = '0;

  // Owned by the main sequence
  int gap_pct = 0;
  bit ready_rand = 1'b0, stall_en = 1'b0;
  // Owned by the driver
  int stall_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Whole load as a word stream; rnd=0 uses the index pattern i of each section.
  task automatic push_load(input bit rnd);
    logic [DW-1:0]  a, b, w;
    logic [QDW-1:0] p;
    p = '0;
    for (int n = 0; n < NL - 1; n++) begin
      a = rnd ? DW'($urandom) : DW'(2 * n);
      b = rnd ? DW'($urandom) : DW'(2 * n + 1);
      fifo_q.push_back(a);
      fifo_q.push_back(b);
      exp_node.push_back({NODE_AW'(n), a, b});
    end
    for (int j = 0; j < NL * LS; j++) begin
      for (int e = 0; e < PS; e++) begin
        w = rnd ? DW'($urandom) : DW'((PS + 1) * j + e);
        fifo_q.push_back(w);
        p[e*DW +: DW] = w;
      end
      w = rnd ? DW'($urandom) : DW'((PS + 1) * j + PS);
      fifo_q.push_back(w);
      exp_leaf.push_back({LEAF_AW'(j / LS), PATCH_AW'(j % LS), w, p});
    end
    for (int q = 0; q < NQ; q++) begin
      for (int e = 0; e < PS; e++) begin
        w = rnd ? DW'($urandom) : DW'(PS * q + e);
        fifo_q.push_back(w);
        p[e*DW +: DW] = w;
      end
      exp_query.push_back({QIDX_W'(q), p});
    end
  endtask

  task automatic pulse_load();
    @(posedge io_clk); #1 load_kdtree = 1'b1;
    @(posedge io_clk); #1 load_kdtree = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int n;
    n = 0;
    while (done_seen == base && n < budget) begin
      @(posedge io_clk);
      n++;
    end
    check(name, done_seen != base, 1'b1);
  endtask

  task automatic end_of_load_checks(input string tag);
    check({tag, "_nodes_left"}, exp_node.size(), 0);
    check({tag, "_leaves_left"}, exp_leaf.size(), 0);
    check({tag, "_queries_left"}, exp_query.size(), 0);
    check({tag, "_busy_low"}, busy, 1'b0);
  endtask

  // Driver: inputs change 1 time unit after the rising edge.
  always @(posedge io_clk) begin
    #1;
    if (pop_pending && fifo_q.size() > 0) fifo_q.delete(0);
    in_fifo_rempty_n = (fifo_q.size() > 0) && ($urandom_range(99) >= gap_pct);
    in_fifo_rdata    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    if (stall_en && q_acc == 10 && stall_cnt < 20) begin
      query_ready = 1'b0;
      if (query_valid) stall_cnt++;
    end else begin
      query_ready = ready_rand ? ($urandom_range(99) < 70) : 1'b1;
    end
  end

  // Compare: outputs sampled on the falling edge against the stream-derived expectations.
  always @(negedge io_clk) begin
    logic last_acc;
    last_acc = 1'b0;
    if (!io_rst_n) begin
      check("rst_ctrl", {in_fifo_deq, node_wen, leaf_wen, query_valid, busy, load_done,
                         node_waddr, leaf_waddr, leaf_wpatch, query_idx}, '0);
      check("rst_wdata", {node_wdata, leaf_wdata}, '0);
      check("rst_qdata", query_data, '0);
      fifo_q.delete();
      exp_node.delete();
      exp_leaf.delete();
      exp_query.delete();
      pop_pending = 1'b0;
      exp_busy    = 1'b0;
      done_exp    = 1'b0;
    end else begin
      pop_pending = in_fifo_deq && in_fifo_rempty_n;
      check("busy", busy, exp_busy);
      if (load_done || done_exp) check("load_done", load_done, done_exp);
      if (load_done) done_seen++;
      done_exp = 1'b0;
      if (in_fifo_deq) check("deq_needs_data", in_fifo_rempty_n, 1'b1);
      if (query_valid || !exp_busy) check("deq_quiet", in_fifo_deq, 1'b0);
      if (node_wen || leaf_wen) check("wen_exclusive", node_wen && leaf_wen, 1'b0);

      if (node_wen) begin
        node_seen++;
        if (node_waddr == 0) cap_node0 = node_wdata;
        if (node_waddr == NODE_AW'(NL - 2)) cap_node62 = node_wdata;
        check("node_expected", exp_node.size() > 0, 1'b1);
        if (exp_node.size() > 0) begin
          check("node_write", {node_waddr, node_wdata}, exp_node[0]);
          exp_node.delete(0);
        end
      end

      if (leaf_wen) begin
        leaf_seen++;
        if (leaf_waddr == 0 && leaf_wpatch == 0) cap_leaf0 = leaf_wdata;
        if (leaf_waddr == LEAF_AW'(NL - 1) && leaf_wpatch == PATCH_AW'(LS - 1))
          cap_leaf_last_idx = leaf_wdata[LDW-1 -: DW];
        check("leaf_expected", exp_leaf.size() > 0, 1'b1);
        if (exp_leaf.size() > 0) begin
          check("leaf_write", {leaf_waddr, leaf_wpatch, leaf_wdata}, exp_leaf[0]);
          exp_leaf.delete(0);
        end
      end

      if (query_valid) begin
        check("query_expected", exp_query.size() > 0, 1'b1);
        if (!query_ready) hold_seen++;
        if (exp_query.size() > 0) begin
          check("query", {query_idx, query_data}, exp_query[0]);
          if (query_ready) begin
            if (q_acc == 0) cap_q0 = query_data;
            cap_qlast = query_idx;
            exp_query.delete(0);
            q_acc++;
            q_seen++;
            if (q_acc == NQ) last_acc = 1'b1;
          end
        end
      end

      if (!exp_busy && load_kdtree) begin
        exp_busy = 1'b1;
        q_acc    = 0;
      end else if (last_acc) begin
        exp_busy = 1'b0;
        done_exp = 1'b1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b_node, b_leaf, b_q, b_done, b_hold, n;
    logic [DW-1:0] first_a, first_b;

    repeat (3) @(posedge io_clk);
    #1 io_rst_n = 1'b1;

    // Index-pattern load, no gaps, ready high except a 20-cycle hold on query 10
    b_node = node_seen; b_leaf = leaf_seen; b_q = q_seen; b_done = done_seen; b_hold = hold_seen;
    gap_pct = 0; ready_rand = 1'b0; stall_en = 1'b1;
    push_load(1'b0);
    pulse_load();
    wait_done(b_done, 20000, "load1_timeout");
    repeat (3) @(posedge io_clk);
    end_of_load_checks("load1");
    check("load1_node_count", node_seen - b_node, NL - 1);
    check("load1_leaf_count", leaf_seen - b_leaf, NL * LS);
    check("load1_query_count", q_seen - b_q, NQ);
    check("load1_done_once", done_seen - b_done, 1);
    check("load1_held_20", (hold_seen - b_hold) >= 20, 1'b1);
    check("node0_data", cap_node0, {11'd0, 11'd1});
    check("node62_data", cap_node62, {11'd124, 11'd125});
    check("leaf0_patch0", cap_leaf0, {11'd5, 11'd4, 11'd3, 11'd2, 11'd1, 11'd0});
    check("leaf63_patch7_idx", cap_leaf_last_idx, 11'd1023);
    check("query0_data", cap_q0, {11'd4, 11'd3, 11'd2, 11'd1, 11'd0});
    check("query_last_idx", cap_qlast, 9'd493);

    // Same stream with FIFO gaps, random ready and a stray start pulse mid-LEAF
    b_node = node_seen; b_leaf = leaf_seen; b_q = q_seen; b_done = done_seen;
    stall_en = 1'b0; gap_pct = 30; ready_rand = 1'b1;
    push_load(1'b0);
    pulse_load();
    n = 0;
    while (leaf_seen - b_leaf < 100 && n < 10000) begin @(posedge io_clk); n++; end
    check("load2_reach_leaf", leaf_seen - b_leaf >= 100, 1'b1);
    pulse_load();
    wait_done(b_done, 20000, "load2_timeout");
    repeat (3) @(posedge io_clk);
    end_of_load_checks("load2");
    check("load2_node_count", node_seen - b_node, NL - 1);
    check("load2_leaf_count", leaf_seen - b_leaf, NL * LS);
    check("load2_done_once", done_seen - b_done, 1);

    // Reset in the middle of the node section
    b_node = node_seen;
    gap_pct = 20;
    push_load(1'b1);
    pulse_load();
    n = 0;
    while (node_seen - b_node < 10 && n < 2000) begin @(posedge io_clk); n++; end
    check("load3_reach_node10", node_seen - b_node >= 10, 1'b1);
    @(posedge io_clk); #1 io_rst_n = 1'b0;
    repeat (3) @(posedge io_clk);
    #1 io_rst_n = 1'b1;

    // Fresh random load: node0 must come from the first new words
    b_node = node_seen; b_leaf = leaf_seen; b_q = q_seen; b_done = done_seen;
    @(posedge io_clk); #2;
    push_load(1'b1);
    first_a = fifo_q[0];
    first_b = fifo_q[1];
    pulse_load();
    wait_done(b_done, 20000, "load4_timeout");
    repeat (3) @(posedge io_clk);
    end_of_load_checks("load4");
    check("load4_node0_fresh", cap_node0, {first_a, first_b});
    check("load4_query_count", q_seen - b_q, NQ);
    check("load4_done_once", done_seen - b_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
